// File: rtl/pipe_pkg.sv
// Shared types and per-boundary widths for the generic pipeline stage register.
// Control bundles are packed so a stage boundary can cast its ctrl vector to named fields.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_e;

  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned IF_ID_CTRL_W  = 8;
  localparam int unsigned ID_EX_DATA_W  = 128;
  localparam int unsigned ID_EX_CTRL_W  = 16;
  localparam int unsigned EX_MEM_DATA_W = 96;
  localparam int unsigned EX_MEM_CTRL_W = 8;
  localparam int unsigned MEM_WB_DATA_W = 64;
  localparam int unsigned MEM_WB_CTRL_W = 4;

  // Control fields carried across IF/ID.
  typedef struct packed {
    logic [3:0] pred_tag;
    logic       pred_taken;
    logic       compressed;
    logic       fetch_fault;
    logic       fetch_valid;
  } if_id_ctrl_t;

  // Control fields carried across ID/EX: operator, operand sources and write enables.
  typedef struct packed {
    logic [5:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       mem_rd;
    logic       ram_wren;
    logic       reg_wren;
    logic       branch;
    logic       jump;
    logic       csr;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [1:0] mem_size;
    logic       mem_signed;
    logic       mem_rd;
    logic       ram_wren;
    logic       reg_wren;
    logic       wb_from_mem;
    logic       csr;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_wren;
    logic       wb_from_mem;
    logic       csr;
    logic       retire;
  } mem_wb_ctrl_t;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of(input pipe_state_e s);
    logic [1:0] occ;
    unique case (s)
      PIPE_FULL: occ = 2'd1;
      PIPE_SKID: occ = 2'd2;
      default:   occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying an opaque data word and a control word.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 16
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with optional 2-entry skid, flush-to-bubble and a
// saturating stall counter for performance debug.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned CTRL_W  = 16,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  pipe_stage_reg_if.slave    in_bus,
  pipe_stage_reg_if.master   out_bus,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  input  logic               stall_clr
);

  pipe_state_e       state, state_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
  logic [DATA_W-1:0] skid_data, skid_data_nxt;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;

  logic in_ready_c;
  logic out_valid_c;
  logic in_fire;
  logic out_fire;

  // Valid is a pure state decode; with the skid enabled ready is too, so out_ready
  // never reaches in_ready combinationally.
  assign out_valid_c = (state != PIPE_EMPTY);
  assign in_ready_c  = SKID_EN ? (state != PIPE_SKID)
                               : ((state == PIPE_EMPTY) || out_bus.ready);

  assign in_fire  = in_bus.valid & in_ready_c;
  assign out_fire = out_valid_c & out_bus.ready;

  assign in_bus.ready  = in_ready_c;
  assign out_bus.valid = out_valid_c;
  assign out_bus.data  = main_data;
  assign out_bus.ctrl  = main_ctrl;
  assign occupancy     = occ_of(state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PIPE_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
    end
  end

  // Next-state: flush dominates and turns every held entry into a bubble (ctrl only).
  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;

    if (flush) begin
      state_nxt     = PIPE_EMPTY;
      main_ctrl_nxt = '0;
      skid_ctrl_nxt = '0;
    end else begin
      unique case (state)
        PIPE_EMPTY: begin
          if (in_fire) begin
            state_nxt     = PIPE_FULL;
            main_data_nxt = in_bus.data;
            main_ctrl_nxt = in_bus.ctrl;
          end
        end
        PIPE_FULL: begin
          if (in_fire && out_fire) begin
            main_data_nxt = in_bus.data;
            main_ctrl_nxt = in_bus.ctrl;
          end else if (in_fire && SKID_EN) begin
            state_nxt     = PIPE_SKID;
            skid_data_nxt = in_bus.data;
            skid_ctrl_nxt = in_bus.ctrl;
          end else if (out_fire) begin
            state_nxt     = PIPE_EMPTY;
            main_ctrl_nxt = '0;
          end
        end
        PIPE_SKID: begin
          if (out_fire) begin
            state_nxt     = PIPE_FULL;
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
            skid_ctrl_nxt = '0;
          end
        end
        default: begin
          state_nxt     = PIPE_EMPTY;
          main_ctrl_nxt = '0;
          skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

  // Stall is sampled on the pre-flush state, so a flush cycle still counts.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (out_valid_c & ~out_bus.ready),
    .clr     (stall_clr),
    .count   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance share
// stimulus; each is compared against a queue-based reference of the stage.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic stall_clr;
  logic [1:0]  occ_a, occ_b;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_in ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_out ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_in ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_out ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_bus(a_in), .out_bus(a_out), .flush(flush),
    .occupancy(occ_a), .stall_cnt(stall_a), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_bus(b_in), .out_bus(b_out), .flush(flush),
    .occupancy(occ_b), .stall_cnt(stall_b), .stall_clr(stall_clr)
  );

  logic          ir [2];
  logic          ov [2];
  logic [DW-1:0] od [2];
  logic [CW-1:0] oc [2];
  logic [1:0]    oo [2];
  logic [15:0]   sc [2];

  assign ir[0] = a_in.ready;   assign ir[1] = b_in.ready;
  assign ov[0] = a_out.valid;  assign ov[1] = b_out.valid;
  assign od[0] = a_out.data;   assign od[1] = b_out.data;
  assign oc[0] = a_out.ctrl;   assign oc[1] = b_out.ctrl;
  assign oo[0] = occ_a;        assign oo[1] = occ_b;
  assign sc[0] = 16'(stall_a); assign sc[1] = stall_b;

  // Reference: entries in flight as a FIFO, capacity 2 with skid and 1 without.
  ent_t        mq [2][$];
  int unsigned mcnt [2];
  int unsigned cmax [2];
  string       nm [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance the model at posedge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl, input logic clr);
    bit   inf [2];
    bit   outf [2];
    bit   stl [2];
    bit   er;
    int   n;
    ent_t e;
    a_in.valid = iv;  a_in.data = d;  a_in.ctrl = c;  a_out.ready = ordy;
    b_in.valid = iv;  b_in.data = d;  b_in.ctrl = c;  b_out.ready = ordy;
    flush = fl;
    stall_clr = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      n  = mq[k].size();
      er = (k == 0) ? (n < 2) : ((n == 0) || ordy);
      chk({nm[k], ".in_ready"},  64'(ir[k]), 64'(er));
      chk({nm[k], ".out_valid"}, 64'(ov[k]), 64'(n > 0));
      chk({nm[k], ".out_ctrl"},  64'(oc[k]), (n > 0) ? 64'(mq[k][0].c) : 64'd0);
      if (n > 0) chk({nm[k], ".out_data"}, 64'(od[k]), 64'(mq[k][0].d));
      chk({nm[k], ".occupancy"}, 64'(oo[k]), 64'(n));
      chk({nm[k], ".stall_cnt"}, 64'(sc[k]), 64'(mcnt[k]));
      inf[k]  = iv && er;
      outf[k] = (n > 0) && ordy;
      stl[k]  = (n > 0) && !ordy;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (clr) mcnt[k] = 0;
      else if (stl[k] && mcnt[k] < cmax[k]) mcnt[k]++;
      if (fl) begin
        mq[k].delete();
      end else begin
        if (outf[k]) void'(mq[k].pop_front());
        if (inf[k]) begin
          e.d = d;
          e.c = c;
          mq[k].push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    nm[0] = "skid";  nm[1] = "noskid";
    cmax[0] = 15;    cmax[1] = 65535;
    reset_n = 1'b0;
    flush = 1'b0;
    stall_clr = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_in.ctrl = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_in.ctrl = '0; b_out.ready = 1'b0;
    model_reset();
    #1;
    chk("rst.out_valid", 64'(a_out.valid), 64'd0);
    chk("rst.in_ready",  64'(a_in.ready),  64'd1);
    chk("rst.out_data",  64'(a_out.data),  64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Streaming: eight back-to-back transfers, then drain.
    for (int i = 0; i < 8; i++) step(1'b1, DW'(i), 16'h00FF, 1'b1, 1'b0, 1'b0);
    repeat (2) idle(1'b1);

    // Backpressure: A and B stack up, then leave in order.
    step(1'b1, 64'hA, 16'h0A0A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hB, 16'h0B0B, 1'b0, 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    chk("skid.occ_full", 64'(occ_a), 64'd2);
    repeat (3) idle(1'b1);

    // Flush with a full stage and a concurrent input C.
    step(1'b1, 64'h1, 16'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h2, 16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hC, 16'hCCCC, 1'b0, 1'b1, 1'b0);
    chk("flush.occ",  64'(occ_a),      64'd0);
    chk("flush.ctrl", 64'(a_out.ctrl), 64'd0);
    repeat (2) idle(1'b1);

    // Stall counter saturation and clear-over-increment.
    step(1'b1, 64'h5, 16'h0055, 1'b0, 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    chk("skid.stall_sat", 64'(stall_a), 64'hF);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("skid.stall_clr", 64'(stall_a), 64'd0);
    repeat (2) idle(1'b1);

    // Reset mid-transfer with both skid entries held.
    step(1'b1, 64'hD1, 16'hD1D1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hD2, 16'hD2D2, 1'b0, 1'b0, 1'b0);
    a_in.valid = 1'b0; b_in.valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(a_out.valid), 64'd0);
    chk("arst.out_ctrl",  64'(a_out.ctrl),  64'd0);
    chk("arst.occ",       64'(occ_a),       64'd0);
    chk("arst.stall",     64'(stall_a),     64'd0);
    chk("arst.in_ready",  64'(a_in.ready),  64'd1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic with occasional flush and clear.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom}, CW'($urandom),
           (i % 100 < 50) ? (($urandom % 4) != 0) : (($urandom % 3) == 0),
           ($urandom % 20) == 0, ($urandom % 30) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EX register: one generic pipeline stage for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data bundle plus a control bundle under a valid/ready handshake.
- Optional two-entry skid buffer breaks the combinational ready path.
- Synchronous flush inserts bubbles by zeroing the control bits (reg_wren, ram_wren, ...); a saturating stall counter supports performance debug.

Parameters:
- DATA_W, 128: width of the data bundle (pc, rs1, rs2, imm, ...); never cleared except by reset.
- CTRL_W, 16: width of the control bundle; forced to 0 on reset and flush (bubble).
- SKID_EN, 1: 1 gives a registered in_ready with a 2-entry skid; 0 gives a single entry with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept.
- in_data, input, DATA_W: upstream data bundle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- out_valid, output, 1: main entry valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: main entry data.
- out_ctrl, output, CTRL_W: main entry control.
- flush, input, 1: synchronous kill of all held entries.
- occupancy, output, 2: entries held (0..2).
- stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0.
- stall_clr, input, 1: synchronous clear of stall_cnt.

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (async, reset_n=0):
  - state=EMPTY, out_valid=0, out_data=0, out_ctrl=0, skid regs=0, occupancy=0, stall_cnt=0.
  - in_ready=1, since it is decoded from state.
- SKID_EN=1 states (in_ready = state!=SKID, decoded from flops only):
  - EMPTY: in_fire -> FULL, main<=in.
  - FULL, in_fire & out_fire -> FULL, main<=in.
  - FULL, in_fire & !out_fire -> SKID, skid<=in, main unchanged.
  - FULL, !in_fire & out_fire -> EMPTY, out_ctrl<=0.
  - FULL, neither -> hold.
  - SKID, out_fire -> FULL, main<=skid, skid_ctrl<=0.
  - SKID, no out_fire -> hold; in_ready=0.
- SKID_EN=0: only EMPTY/FULL.
  - in_ready = !out_valid | out_ready (combinational).
  - FULL with in_fire & out_fire -> FULL, main<=in.
- Latency: one cycle in_fire -> out_valid when the stage is empty; zero bubbles at full throughput (one transfer per cycle).
- Ordering: strict FIFO; the skid entry always leaves after the main entry.
- Flush (highest priority):
  - Next state is EMPTY; main and skid ctrl<=0; data regs keep their values.
  - An entry presented the same cycle with in_fire is discarded.
  - A simultaneous out_fire still counts as delivered downstream; downstream owns the kill.
- Bubble invariant: out_valid=0 implies out_ctrl==0, always.
- occupancy: EMPTY=0, FULL=1, SKID=2; registered state decode.
- stall_cnt:
  - +1 on each cycle with out_valid & !out_ready.
  - Saturates at all ones with no wrap.
  - stall_clr sets it to 0 and wins over increment.
  - A flush cycle counts if the condition holds before the flush.
- No combinational path from in_valid/in_data to any output.
- With SKID_EN=1, no combinational path out_ready -> in_ready.

Decomposition:
- Shared package pipe_pkg:
  - state enum PIPE_EMPTY=2'd0, PIPE_FULL=2'd1, PIPE_SKID=2'd2.
  - Per-boundary DATA_W/CTRL_W constants, e.g. ID_EX_DATA_W=128, ID_EX_CTRL_W=16, so the control bundle packs operator/src/wren fields.
- One sub-module sat_counter (CNT_W; ports inc, clr, count), also reused by other perf counters.

Test Plan:
- Reset mid-transfer:
  - Stimulus: fill both entries, assert reset_n=0 asynchronously between edges.
  - Response: out_valid/out_ctrl/occupancy/stall_cnt drop to 0 immediately; in_ready=1.
- Streaming:
  - Stimulus: in_valid=1 for 8 cycles with data 0..7, ctrl 16'h00FF, out_ready=1.
  - Response: outputs 0..7 on consecutive cycles, first one cycle after the first in_fire.
- Backpressure / skid:
  - Stimulus: send A,B with out_ready=0.
  - Response: occupancy=2, in_ready=0 the cycle after B, stall_cnt increments.
  - Then: raise out_ready and expect A then B in order, in_ready=1 after A leaves.
- Flush with concurrent input:
  - Stimulus: occupancy=2, flush=1 with in_valid=1 (C).
  - Response: next cycle occupancy=0, out_valid=0, out_ctrl=0; C never appears.
- Stall counter:
  - Stimulus: CNT_W=4, hold a stall for 20 cycles.
  - Response: stall_cnt=4'hF saturated.
  - Stimulus: stall_clr together with a stall cycle.
  - Response: stall_cnt=0.
- SKID_EN=0 variant:
  - Stimulus: FULL, out_ready=1, in_valid=1.
  - Response: in_ready=1 in the same cycle and main is replaced with no bubble.
  - Stimulus: out_ready=0.
  - Response: in_ready=0 combinationally.
